// File: rtl/hit_judge.sv
// ============================================================================
// Module   : hit_judge
// Purpose  : Judges button presses against the active-mole mask and issues
//            miss / partial-hit / full-clear pulses plus a per-hole clear.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hit_judge #(
  parameter int NUM_HOLES      = 4,
  parameter int LOCKOUT_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 game_active,
  input  logic [NUM_HOLES-1:0] buttons,
  input  logic [NUM_HOLES-1:0] mole_active,
  input  logic                 mole_expired,
  output logic                 miss,
  output logic                 non_full_clear_hit,
  output logic                 full_clear_hit,
  output logic [NUM_HOLES-1:0] mole_clear,
  output logic                 busy
);

  localparam int CNT_W = (LOCKOUT_CYCLES > 0) ? $clog2(LOCKOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCKOUT_CYCLES);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    LOCKOUT = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 pending_q, pending_d;
  logic [NUM_HOLES-1:0] sync1_q, sync1_d;
  logic [NUM_HOLES-1:0] sync2_q, sync2_d;
  logic [NUM_HOLES-1:0] prev_q, prev_d;
  logic [NUM_HOLES-1:0] edge_q, edge_d;
  logic                 miss_q, miss_d;
  logic                 nfch_q, nfch_d;
  logic                 fch_q, fch_d;
  logic [NUM_HOLES-1:0] clear_q, clear_d;

  logic [NUM_HOLES-1:0] sel_onehot;
  logic                 sel_found;
  logic                 sel_hit;
  logic                 sel_full;
  logic                 want_exp;
  logic                 decide;

  // Lowest-index edge wins; the rest of that cycle's edges are discarded.
  always_comb begin
    sel_onehot = '0;
    sel_found  = 1'b0;
    for (int k = 0; k < NUM_HOLES; k++) begin
      if (edge_q[k] && !sel_found) begin
        sel_found     = 1'b1;
        sel_onehot[k] = 1'b1;
      end
    end
    sel_hit  = |(sel_onehot & mole_active);
    sel_full = (mole_active == sel_onehot);
  end

  always_comb begin
    sync1_d   = buttons;
    sync2_d   = sync1_q;
    prev_d    = sync2_q;
    edge_d    = sync2_q & ~prev_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    miss_d    = 1'b0;
    nfch_d    = 1'b0;
    fch_d     = 1'b0;
    clear_d   = '0;
    want_exp  = pending_q | mole_expired;
    decide    = 1'b0;

    if (!game_active) begin
      state_d   = IDLE;
      cnt_d     = '0;
      pending_d = 1'b0;
    end else begin
      decide = (state_q == IDLE) && sel_found;
      if (decide) begin
        if (!sel_hit) begin
          miss_d = 1'b1;
        end else if (sel_full) begin
          fch_d   = 1'b1;
          clear_d = sel_onehot;
        end else begin
          nfch_d  = 1'b1;
          clear_d = sel_onehot;
        end
        // An expiry colliding with a judgement is deferred by one cycle.
        pending_d = want_exp;
        if (LOCKOUT_CYCLES > 0) begin
          state_d = LOCKOUT;
          cnt_d   = LOCK_LOAD;
        end
      end else if (want_exp) begin
        miss_d    = 1'b1;
        pending_d = 1'b0;
      end

      if (state_q == LOCKOUT) begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_d == '0) begin
          state_d = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      edge_q    <= '0;
      miss_q    <= 1'b0;
      nfch_q    <= 1'b0;
      fch_q     <= 1'b0;
      clear_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      prev_q    <= prev_d;
      edge_q    <= edge_d;
      miss_q    <= miss_d;
      nfch_q    <= nfch_d;
      fch_q     <= fch_d;
      clear_q   <= clear_d;
    end
  end

  assign miss               = miss_q;
  assign non_full_clear_hit = nfch_q;
  assign full_clear_hit     = fch_q;
  assign mole_clear         = clear_q;
  assign busy               = (state_q == LOCKOUT);

endmodule

`default_nettype wire

// File: tb/tb_hit_judge.sv
// ============================================================================
// Module   : tb_hit_judge
// Purpose  : Directed plus randomized checking of hit_judge against a
//            cycle-indexed behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hit_judge;

  localparam int NH = 4;
  localparam int L  = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          game_active = 1'b0;
  logic [NH-1:0] buttons = '0;
  logic [NH-1:0] mole_active = '0;
  logic          mole_expired = 1'b0;
  logic          miss;
  logic          non_full_clear_hit;
  logic          full_clear_hit;
  logic [NH-1:0] mole_clear;
  logic          busy;

  int vectors = 0;
  int miscompares = 0;

  hit_judge #(.NUM_HOLES(NH), .LOCKOUT_CYCLES(L)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .game_active       (game_active),
    .buttons           (buttons),
    .mole_active       (mole_active),
    .mole_expired      (mole_expired),
    .miss              (miss),
    .non_full_clear_hit(non_full_clear_hit),
    .full_clear_hit    (full_clear_hit),
    .mole_clear        (mole_clear),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  // Model: button samples indexed by clock edge; a press is judged three
  // edges after its first sample, and lockout is a window after the last
  // accepted judgement.
  logic [NH-1:0] hist [0:4];
  longint        n_edge = 0;
  longint        last_dec = -100;
  bit            pend = 0;
  logic          e_miss, e_nf, e_fc, e_busy;
  logic [NH-1:0] e_clr;

  task automatic model_reset();
    for (int i = 0; i < 5; i++) hist[i] = '0;
    pend = 0;
    last_dec = -100;
    e_miss = 0; e_nf = 0; e_fc = 0; e_busy = 0; e_clr = '0;
  endtask

  task automatic model_step();
    logic [NH-1:0] e;
    int sel;
    n_edge++;
    if (!reset_n) begin
      model_reset();
      return;
    end
    for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = buttons;
    e = hist[3] & ~hist[4];
    e_miss = 0; e_nf = 0; e_fc = 0; e_clr = '0;
    if (!game_active) begin
      pend = 0;
      last_dec = -100;
      e_busy = 0;
    end else begin
      if ((n_edge - 1 - last_dec) >= L && e != 0) begin
        sel = -1;
        for (int i = NH - 1; i >= 0; i--) if (e[i]) sel = i;
        if (!mole_active[sel]) e_miss = 1;
        else if (mole_active == NH'(1 << sel)) begin e_fc = 1; e_clr = NH'(1 << sel); end
        else begin e_nf = 1; e_clr = NH'(1 << sel); end
        pend = pend | mole_expired;
        last_dec = n_edge;
      end else if (pend || mole_expired) begin
        e_miss = 1;
        pend = 0;
      end
      e_busy = (n_edge - last_dec) < L;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s @edge %0d: observed=%0h expected=%0h", tag, n_edge, got, exp);
    end
  endtask

  task automatic check_all();
    chk("miss", 32'(miss), 32'(e_miss));
    chk("non_full_clear_hit", 32'(non_full_clear_hit), 32'(e_nf));
    chk("full_clear_hit", 32'(full_clear_hit), 32'(e_fc));
    chk("mole_clear", 32'(mole_clear), 32'(e_clr));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("exclusive", 32'((32'(miss) + 32'(non_full_clear_hit) + 32'(full_clear_hit)) <= 1), 32'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    ticks(2);
    reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    ticks(3);
    reset_n = 1'b1;
    ticks(2);
    game_active = 1'b1;
    ticks(5);

    // Partial hit with a 3-cycle hold, then lockout
    mole_active = 4'b0110; buttons = 4'b0010;
    ticks(3);
    buttons = 4'b0000;
    ticks(10);

    // Full clear
    mole_active = 4'b0100; buttons = 4'b0100;
    tick();
    buttons = 4'b0000;
    ticks(10);

    // Miss, then a second press landing inside lockout
    mole_active = 4'b0001; buttons = 4'b1000;
    tick();
    buttons = 4'b0000;
    tick();
    buttons = 4'b0001;
    tick();
    buttons = 4'b0000;
    ticks(10);

    // Simultaneous edges: lowest index judged
    mole_active = 4'b1000; buttons = 4'b1010;
    tick();
    buttons = 4'b0000;
    ticks(10);

    // Expiry in the decision cycle of a partial hit
    mole_active = 4'b0011; buttons = 4'b0001;
    tick();
    buttons = 4'b0000;
    ticks(2);
    mole_expired = 1'b1;
    tick();
    mole_expired = 1'b0;
    ticks(10);

    // Reset during lockout, held button across game start
    mole_active = 4'b0001; buttons = 4'b0001;
    ticks(5);
    do_reset();
    game_active = 1'b0;
    ticks(5);
    game_active = 1'b1;
    ticks(10);
    buttons = 4'b0000;
    ticks(5);

    // Randomized phase
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) buttons = NH'($urandom_range(0, 15));
      mole_active  = NH'($urandom_range(0, 15));
      mole_expired = ($urandom_range(0, 5) == 0);
      game_active  = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      tick();
    end
    mole_expired = 1'b0;
    ticks(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
